// File: rtl/xgmii_fault_rs.sv
// XGMII reconciliation-sublayer link-fault stage: RX fault-sequence detection and TX override.
// Build option XGMII_FAULT_CNT_EN enables the saturating fault-entry counters.
module xgmii_fault_rs #(
  parameter int C_SEQ_THRESH = 4,
  parameter int C_COL_WINDOW = 128
) (
  input  logic        clk156,
  input  logic        rst_n,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic [63:0] mac_txd,
  input  logic [7:0]  mac_txc,
  input  logic        fault_inhibit,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic [1:0]  link_fault,
  output logic        link_up,
  output logic [15:0] local_fault_cnt,
  output logic [15:0] remote_fault_cnt
);

  localparam int CW = $clog2(C_COL_WINDOW);
  localparam logic [3:0]    SEQ_MAX  = 4'(C_SEQ_THRESH);
  localparam logic [CW-1:0] COL_LAST = CW'(C_COL_WINDOW - 1);
  localparam logic [1:0]    LF_OK    = 2'b00;
  localparam logic [1:0]    LF_LOCAL = 2'b01;
  localparam logic [1:0]    LF_REMOTE = 2'b10;
  localparam logic [63:0]   IDLE_D   = 64'h0707070707070707;
  localparam logic [7:0]    IDLE_C   = 8'hFF;
  localparam logic [63:0]   RFSEQ_D  = 64'h0200009C_0200009C;
  localparam logic [7:0]    RFSEQ_C  = 8'h11;

  typedef struct packed {
    logic [1:0]    fault;
    logic [1:0]    last;
    logic [3:0]    seq;
    logic [CW-1:0] col;
  } fault_st_t;

  // Advances the fault state machine by one 4-lane column.
  function automatic fault_st_t col_step(input fault_st_t s, input logic [31:0] d, input logic [3:0] c);
    fault_st_t  n;
    logic [1:0] t;
    n = s;
    t = LF_OK;
    if ((c == 4'b0001) && (d[7:0] == 8'h9C) && (d[23:8] == 16'h0000)) begin
      if (d[31:24] == 8'h01) begin
        t = LF_LOCAL;
      end else if (d[31:24] == 8'h02) begin
        t = LF_REMOTE;
      end else begin
        t = LF_OK;
      end
    end else begin
      t = LF_OK;
    end
    if (t != LF_OK) begin
      n.col = '0;
      if (t == s.last) begin
        n.seq = (s.seq < SEQ_MAX) ? (s.seq + 4'd1) : SEQ_MAX;
      end else begin
        n.last = t;
        n.seq  = 4'd1;
      end
      n.fault = (n.seq == SEQ_MAX) ? t : s.fault;
    end else if (s.col == COL_LAST) begin
      n.col   = '0;
      n.seq   = 4'd0;
      n.last  = LF_OK;
      n.fault = LF_OK;
    end else begin
      n.col = s.col + CW'(1);
    end
    return n;
  endfunction

  fault_st_t st_r;
  fault_st_t st_a_s;
  fault_st_t st_b_s;

  // Column A is resolved first and feeds column B within the same cycle.
  always_comb begin
    st_a_s = col_step(st_r, xgmii_rxd[31:0], xgmii_rxc[3:0]);
    st_b_s = col_step(st_a_s, xgmii_rxd[63:32], xgmii_rxc[7:4]);
  end

  // Fault state and link status registers.
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      st_r    <= '0;
      link_up <= 1'b1;
    end else begin
      st_r    <= st_b_s;
      link_up <= (st_b_s.fault == LF_OK);
    end
  end

  assign link_fault = st_r.fault;

  // TX override follows the fault value held before this edge; 11 falls back to passthrough.
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      xgmii_txd <= IDLE_D;
      xgmii_txc <= IDLE_C;
    end else if (fault_inhibit) begin
      xgmii_txd <= mac_txd;
      xgmii_txc <= mac_txc;
    end else begin
      case (st_r.fault)
        LF_LOCAL: begin
          xgmii_txd <= RFSEQ_D;
          xgmii_txc <= RFSEQ_C;
        end
        LF_REMOTE: begin
          xgmii_txd <= IDLE_D;
          xgmii_txc <= IDLE_C;
        end
        default: begin
          xgmii_txd <= mac_txd;
          xgmii_txc <= mac_txc;
        end
      endcase
    end
  end

`ifdef XGMII_FAULT_CNT_EN
  logic [15:0] lf_cnt_r;
  logic [15:0] rf_cnt_r;

  // Saturating counts of entries into each fault type.
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      lf_cnt_r <= 16'h0000;
      rf_cnt_r <= 16'h0000;
    end else begin
      if ((st_b_s.fault == LF_LOCAL) && (st_r.fault != LF_LOCAL) && (lf_cnt_r != 16'hFFFF)) begin
        lf_cnt_r <= lf_cnt_r + 16'd1;
      end else begin
        lf_cnt_r <= lf_cnt_r;
      end
      if ((st_b_s.fault == LF_REMOTE) && (st_r.fault != LF_REMOTE) && (rf_cnt_r != 16'hFFFF)) begin
        rf_cnt_r <= rf_cnt_r + 16'd1;
      end else begin
        rf_cnt_r <= rf_cnt_r;
      end
    end
  end

  assign local_fault_cnt  = lf_cnt_r;
  assign remote_fault_cnt = rf_cnt_r;
`else
  assign local_fault_cnt  = 16'h0000;
  assign remote_fault_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_xgmii_fault_rs.sv
// Directed testbench for xgmii_fault_rs; expected values are hand-derived per step.
module tb_xgmii_fault_rs;

  localparam logic [63:0] IDLE_D = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_C = 8'hFF;
  localparam logic [63:0] LF_D   = 64'h0100009C_0100009C;
  localparam logic [63:0] RF_D   = 64'h0200009C_0200009C;
  localparam logic [7:0]  SEQ_C  = 8'h11;
  localparam logic [63:0] MAC_D  = 64'h1122334455667788;
  localparam logic [7:0]  MAC_C  = 8'h00;

`ifdef XGMII_FAULT_CNT_EN
  localparam logic [15:0] EXP_ONE = 16'd1;
`else
  localparam logic [15:0] EXP_ONE = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic [63:0] mac_txd;
  logic [7:0]  mac_txc;
  logic        fault_inhibit;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic [1:0]  link_fault;
  logic        link_up;
  logic [15:0] local_fault_cnt;
  logic [15:0] remote_fault_cnt;

  int n_pass = 0;
  int n_total = 0;

  xgmii_fault_rs dut (
    .clk156(clk), .rst_n(rst_n), .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
    .mac_txd(mac_txd), .mac_txc(mac_txc), .fault_inhibit(fault_inhibit),
    .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc), .link_fault(link_fault),
    .link_up(link_up), .local_fault_cnt(local_fault_cnt), .remote_fault_cnt(remote_fault_cnt)
  );

  always #3 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    xgmii_rxd = IDLE_D;
    xgmii_rxc = IDLE_C;
    mac_txd = MAC_D;
    mac_txc = MAC_C;
    fault_inhibit = 1'b0;
    tick();
    tick();
    check("rst_txd", xgmii_txd, IDLE_D);
    check("rst_txc", {56'd0, xgmii_txc}, {56'd0, IDLE_C});
    check("rst_fault", {62'd0, link_fault}, 64'd0);
    check("rst_lcnt", {48'd0, local_fault_cnt}, 64'd0);
    rst_n = 1'b1;

    // idle RX, passthrough with one-cycle delay
    for (int i = 0; i < 10; i++) begin
      mac_txd = 64'hA5A5_0000_0000_0000 + 64'(i * 17);
      mac_txc = 8'(i);
      tick();
      check("pass_txd", xgmii_txd, 64'hA5A5_0000_0000_0000 + 64'(i * 17));
      check("pass_txc", {56'd0, xgmii_txc}, 64'(i));
      check("ok_fault", {62'd0, link_fault}, 64'd0);
      check("ok_up", {63'd0, link_up}, 64'd1);
    end
    mac_txd = MAC_D;
    mac_txc = MAC_C;

    // local fault after four local columns
    xgmii_rxd = LF_D;
    xgmii_rxc = SEQ_C;
    tick();
    check("lf_half", {62'd0, link_fault}, 64'd0);
    tick();
    check("lf_set", {62'd0, link_fault}, 64'd1);
    check("lf_up", {63'd0, link_up}, 64'd0);
    check("lf_tx_lag", xgmii_txd, MAC_D);
    xgmii_rxd = IDLE_D;
    xgmii_rxc = IDLE_C;
    tick();
    check("lf_txd", xgmii_txd, RF_D);
    check("lf_txc", {56'd0, xgmii_txc}, {56'd0, SEQ_C});
    check("lf_cnt", {48'd0, local_fault_cnt}, {48'd0, EXP_ONE});
    for (int i = 0; i < 62; i++) tick();
    check("lf_hold63", {62'd0, link_fault}, 64'd1);
    check("lf_hold_tx", xgmii_txd, RF_D);
    tick();
    check("lf_clear64", {62'd0, link_fault}, 64'd0);
    check("lf_clear_up", {63'd0, link_up}, 64'd1);
    check("lf_clear_lag", xgmii_txd, RF_D);
    tick();
    check("lf_pass_back", xgmii_txd, MAC_D);

    // alternating local/remote columns never accumulate
    xgmii_rxd = 64'h0200009C_0100009C;
    xgmii_rxc = SEQ_C;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("alt_fault", {62'd0, link_fault}, 64'd0);
    end
    xgmii_rxd = IDLE_D;
    xgmii_rxc = IDLE_C;
    for (int i = 0; i < 64; i++) tick();

    // 3 remote, 128 idle, 1 remote: window clears the partial count
    xgmii_rxd = RF_D;
    xgmii_rxc = SEQ_C;
    tick();
    xgmii_rxd = 64'h07070707_0200009C;
    xgmii_rxc = 8'hF1;
    tick();
    xgmii_rxd = IDLE_D;
    xgmii_rxc = IDLE_C;
    for (int i = 0; i < 63; i++) tick();
    xgmii_rxd = 64'h0200009C_07070707;
    xgmii_rxc = 8'h1F;
    tick();
    check("win_fault", {62'd0, link_fault}, 64'd0);
    xgmii_rxd = RF_D;
    xgmii_rxc = SEQ_C;
    tick();
    check("rf_three", {62'd0, link_fault}, 64'd0);
    tick();
    check("rf_set", {62'd0, link_fault}, 64'd2);
    check("rf_up", {63'd0, link_up}, 64'd0);
    xgmii_rxd = IDLE_D;
    xgmii_rxc = IDLE_C;
    tick();
    check("rf_txd", xgmii_txd, IDLE_D);
    check("rf_txc", {56'd0, xgmii_txc}, {56'd0, IDLE_C});
    check("rf_cnt", {48'd0, remote_fault_cnt}, {48'd0, EXP_ONE});
    check("rf_lcnt", {48'd0, local_fault_cnt}, {48'd0, EXP_ONE});

    // inhibit forces passthrough while remote fault persists
    fault_inhibit = 1'b1;
    mac_txd = 64'hCAFE_F00D_1234_5678;
    mac_txc = 8'h81;
    tick();
    check("inh_txd", xgmii_txd, 64'hCAFE_F00D_1234_5678);
    check("inh_txc", {56'd0, xgmii_txc}, 64'h81);
    check("inh_fault", {62'd0, link_fault}, 64'd2);

    // asynchronous reset mid-fault
    rst_n = 1'b0;
    #1;
    check("arst_fault", {62'd0, link_fault}, 64'd0);
    check("arst_up", {63'd0, link_up}, 64'd1);
    check("arst_txd", xgmii_txd, IDLE_D);
    check("arst_txc", {56'd0, xgmii_txc}, {56'd0, IDLE_C});
    check("arst_rcnt", {48'd0, remote_fault_cnt}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/xgmii_fault_rs.md
Name: xgmii_fault_rs

Overview:
- Reconciliation-sublayer link-fault stage on the 64-bit XGMII at 156.25 MHz, sitting between the 10G MAC and the PHY interface block.
- RX side: scans the PHY-side xgmii_rxd/xgmii_rxc for local/remote fault sequence ordered sets and runs the link-fault state machine.
- TX side: passes MAC xgmii_txd/xgmii_txc to the PHY, replacing them with remote-fault sequences or idles while a fault is active.

Parameters:
C_SEQ_THRESH, 4, consecutive same-type sequence columns required to declare a fault (2..15)
C_COL_WINDOW, 128, consecutive non-sequence columns that clear seq_cnt and the fault (power of 2, 16..1024)

Ports:
clk156  in  1  XGMII clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
xgmii_rxd  in  64  RX data from PHY interface, lane0 = bits[7:0]
xgmii_rxc  in  8  RX control, bit n = lane n
mac_txd  in  64  TX data from MAC
mac_txc  in  8  TX control from MAC
fault_inhibit  in  1  1 = never override TX (unidirectional/debug mode)
xgmii_txd  out  64  TX data to PHY interface
xgmii_txc  out  8  TX control to PHY interface
link_fault  out  2  00 OK, 01 local fault, 10 remote fault
link_up  out  1  link_fault==00
local_fault_cnt  out  16  local-fault entries (see Optional Feature)
remote_fault_cnt  out  16  remote-fault entries (see Optional Feature)

Behaviour:
- Reset (rst_n=0, async): link_fault=00, link_up=1 after release, seq_cnt=0, last_type=00, col_cnt=0, xgmii_txd=64'h0707070707070707, xgmii_txc=8'hFF, counters 0.
- Two columns per cycle: A = lanes 0-3, B = lanes 4-7. A is evaluated before B in the same cycle; the result of A feeds B combinationally.
- Sequence column: ctrl nibble 4'b0001, lane0=8'h9C, lanes1-2=8'h00, lane3=8'h01 (type local) or 8'h02 (type remote).
  - Any other lane3 value is a non-sequence column.
- Per sequence column of type t:
  - col_cnt<=0.
  - If t==last_type: seq_cnt<=min(seq_cnt+1, C_SEQ_THRESH).
  - Else: last_type<=t, seq_cnt<=1.
  - If the resulting seq_cnt==C_SEQ_THRESH: link_fault<=t.
- Per non-sequence column:
  - col_cnt<=col_cnt+1.
  - On reaching C_COL_WINDOW: seq_cnt<=0, last_type<=00, link_fault<=00, col_cnt<=0.
- Local and remote sequences do not accumulate together. A type change while in fault sets last_type and seq_cnt only; link_fault changes to the new type only after C_SEQ_THRESH consecutive columns of that type.
- Latency: a column seen in cycle N is reflected in link_fault/link_up after edge N (1 cycle).
- TX mux, registered, 1-cycle latency, evaluated on the link_fault value at the current edge:
  - fault_inhibit=1 or link_fault=00: xgmii_txd<=mac_txd, xgmii_txc<=mac_txc.
  - link_fault=01 (local): xgmii_txd<=64'h0200009C_0200009C, xgmii_txc<=8'h11 (remote-fault sequence in both columns).
  - link_fault=10 (remote): idle, 64'h0707070707070707 / 8'hFF.
- Override switches on word boundaries only. A frame in flight is truncated abruptly; the MAC detects this via its own fault handling.
- link_fault=11 is unreachable. If forced, treat as 00 in the TX mux.
- Reset mid-frame: TX immediately returns idles; all state cleared.

Optional Feature:
- Macro XGMII_FAULT_CNT_EN.
- Defined:
  - local_fault_cnt/remote_fault_cnt are 16-bit saturating counters (stick at 16'hFFFF).
  - Each increments by 1 on the edge where link_fault changes into 01/10 respectively, from any other value.
  - Both clear only on reset.
- Undefined: both ports driven constant 0, no counter flops.

Test Plan:
- Reset, then 10 cycles of idle RX -> link_fault=00, link_up=1, xgmii_txd/txc track mac_txd/txc with 1-cycle delay.
- 2 cycles of rxd=64'h0100009C_0100009C, rxc=8'h11 -> link_fault=01 after 2nd edge. Next cycle: xgmii_txd=64'h0200009C_0200009C, txc=8'h11; local_fault_cnt=1 (macro on).
- From local fault, 63 idle cycles -> link_fault stays 01; 64th idle cycle -> link_fault=00 and TX passthrough on the following edge.
- Alternating local/remote sequence columns for 20 cycles from OK -> link_fault stays 00, since seq_cnt never exceeds 1.
- 3 remote sequence columns, then 128 idle columns, then 1 remote column -> link_fault stays 00. Then 4 consecutive remote columns -> link_fault=10, TX outputs idles 64'h0707070707070707/8'hFF.
- Remote fault active with fault_inhibit=1 -> TX passthrough of mac_txd. Assert rst_n=0 mid-fault -> link_fault=00 and TX idles asynchronously.
